// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared down-counter to
// NREQ requesters, one timed interval at a time.
// Optional feature macro: COUNTER_ARBITER_ABORT_EN (compiles in i_abort handling).
//
// Ports:
//   i_clk, i_reset         rising-edge clock, synchronous active-high reset
//   i_req[NREQ]            per-requester request, held until its o_done
//   i_count[NREQ*CW]       requester n's interval length in [n*CW +: CW]
//   i_abort                cancel the in-flight interval (feature macro only)
//   o_grant[NREQ]          one-hot owner of the counter, zero when unowned
//   o_done[NREQ]           one-cycle completion pulse to the owner
//   o_aborted              high alongside o_done when the interval was cancelled
//   o_busy                 high whenever the FSM is not idle
//   o_remaining[CW]        counter value while counting, zero otherwise
module counter_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ*CW-1:0] i_count,
   input  logic               i_abort,
   output logic [NREQ-1:0]    o_grant,
   output logic [NREQ-1:0]    o_done,
   output logic               o_aborted,
   output logic               o_busy,
   output logic [CW-1:0]      o_remaining
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   last_q;     // index of the most recent winner
   logic [CW-1:0]   count_q;    // doubles as o_remaining: cleared outside COUNT
   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] done_q;
   logic            aborted_q;
   logic            busy_q;

   // Round-robin winner for the current cycle.
   logic            win_vld;
   logic [IW-1:0]   win_idx;
   logic [IW:0]     cand_sum;
   logic [IW-1:0]   cand;
   logic [NREQ-1:0] grant_d;
   logic [CW-1:0]   count_d;

   logic            abort_req;

`ifdef COUNTER_ARBITER_ABORT_EN
   assign abort_req = i_abort;
`else
   // Abort is compiled out; the port stays so the interface does not change.
   logic unused_abort;
   assign unused_abort = i_abort;
   assign abort_req    = 1'b0;
`endif

   // Scan starts one past the last winner and wraps, so the previous owner
   // has the lowest priority this round.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      cand_sum = '0;
      cand     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand_sum = {1'b0, last_q} + (IW+1)'(i);
         if (cand_sum >= (IW+1)'(NREQ)) begin
            cand_sum = cand_sum - (IW+1)'(NREQ);
         end
         cand = cand_sum[IW-1:0];
         if (!win_vld && i_req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      grant_d = '0;
      grant_d[win_idx] = 1'b1;
      count_d = i_count[win_idx*CW +: CW];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         last_q    <= IW'(NREQ-1);   // requester 0 scanned first after reset
         count_q   <= '0;
         grant_q   <= '0;
         done_q    <= '0;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q    <= '0;
               aborted_q <= 1'b0;
               if (win_vld) begin
                  state_q <= S_COUNT;
                  grant_q <= grant_d;
                  count_q <= count_d;
                  last_q  <= win_idx;
                  busy_q  <= 1'b1;
               end
            end
            S_COUNT: begin
               // Zero is the last counting cycle, so an interval of N holds
               // the grant N+1 cycles and the counter never wraps.
               if (count_q == '0 || abort_req) begin
                  state_q   <= S_DONE;
                  done_q    <= grant_q;
                  grant_q   <= '0;
                  count_q   <= '0;
                  aborted_q <= abort_req;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            S_DONE: begin
               state_q   <= S_IDLE;
               done_q    <= '0;
               aborted_q <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               count_q   <= '0;
               grant_q   <= '0;
               done_q    <= '0;
               aborted_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign o_grant     = grant_q;
   assign o_done      = done_q;
   assign o_aborted   = aborted_q;
   assign o_busy      = busy_q;
   assign o_remaining = count_q;

endmodule
